// File: rtl/relu_store.sv
// relu_store: captures a layer result, applies ReLU in LANES-wide groups, then holds it for a valid/ready consumer.
// Optional macro RELU_SAT_EN: clamps positive elements above SAT_MAX on the non-bypass path.
`ifndef AFFINE
`define AFFINE 4
`endif

module relu_store #(
    parameter int unsigned         DATA_LEN    = 16,
    parameter int unsigned         NUM_ELEM    = 384,
    parameter int unsigned         LANES       = 32,
    parameter logic [3:0]          AFFINE_CODE = 4'd`AFFINE,
    parameter logic [DATA_LEN-1:0] SAT_MAX     = {1'b0, {(DATA_LEN-1){1'b1}}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [3:0]                   cs_layer,
    input  logic [NUM_ELEM*DATA_LEN-1:0] d,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_ELEM*DATA_LEN-1:0] q
);

    localparam int unsigned NUM_GRP = NUM_ELEM / LANES;
    localparam int unsigned CW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam logic [CW-1:0] LAST  = CW'(NUM_GRP - 1);

    typedef logic [LANES-1:0][DATA_LEN-1:0] grp_t;
    typedef logic [NUM_GRP-1:0][LANES-1:0][DATA_LEN-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, RELU, HOLD} state_e;

    state_e        state_q;
    vec_t          q_q;
    logic [CW-1:0] cnt_q;
    logic          byp_q;
    logic          vld_q;
    logic          ovr_q;
    logic          inv_q;
    logic          start;
    grp_t          grp_q;
    grp_t          grp_d;

    function automatic logic [DATA_LEN-1:0] act(
        input logic [DATA_LEN-1:0] x,
        input logic                byp
    );
        if (byp) return x;
        if (x[DATA_LEN-1]) return '0;
`ifdef RELU_SAT_EN
        if ($signed(x) > $signed(SAT_MAX)) return SAT_MAX;
`endif
        return x;
    endfunction

`ifndef RELU_SAT_EN
    logic unused_sat;
    assign unused_sat = ^SAT_MAX;
`endif

    assign start = in_valid & ~inv_q;
    assign grp_q = q_q[cnt_q];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign grp_d[l] = act(grp_q[l], byp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            byp_q   <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            inv_q <= in_valid;
            // A finish edge outside IDLE is dropped but remembered
            if (start && state_q != IDLE) ovr_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q     <= d;
                        byp_q   <= (cs_layer == AFFINE_CODE);
                        cnt_q   <= '0;
                        state_q <= RELU;
                    end
                end
                RELU: begin
                    q_q[cnt_q] <= grp_d;
                    cnt_q      <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= HOLD;
                end
                HOLD: begin
                    if (!vld_q) begin
                        vld_q <= 1'b1;
                    end else if (out_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = vld_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;
    assign q         = q_q;

endmodule

// File: tb/tb_relu_store.sv
// tb_relu_store: randomized vectors against an element-wise ReLU model.
// Covers latency, bypass, backpressure, overrun, async reset and the clamp build.
module tb_relu_store;

    localparam int W  = 16;
    localparam int N  = 384;
    localparam int L  = 32;
    localparam logic [3:0]  AFF  = 4'd4;
    localparam logic [3:0]  CONV = 4'd1;
    localparam logic [15:0] SMAX = 16'h0100;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] cs_layer = 4'd0;
    vec_t       d = '0;
    vec_t       q;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    relu_store #(
        .DATA_LEN(W), .NUM_ELEM(N), .LANES(L),
        .AFFINE_CODE(AFF), .SAT_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .cs_layer(cs_layer), .d(d), .out_ready(out_ready),
        .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .q(q)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_el(input logic [W-1:0] x,
                                            input bit byp);
        if (byp) return x;
        if ($signed(x) < 0) return '0;
`ifdef RELU_SAT_EN
        if ($signed(x) > $signed(SMAX)) return SMAX;
`endif
        return x;
    endfunction

    function automatic vec_t ref_vec(input vec_t v, input logic [3:0] cs);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = ref_el(v[i], cs == AFF);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        return v;
    endfunction

    function automatic int nmis(input vec_t a, input vec_t b);
        int n = 0;
        for (int i = 0; i < N; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input vec_t v, input logic [3:0] cs);
        in_valid = 1'b1;
        d        = v;
        cs_layer = cs;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v, v2, exp;
        int   k;

        #2 rst_n = 1'b0;
        #20;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_q", nmis(q, '0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) v[i] = (i % 2 == 0) ? 16'd5 : 16'hFFFB;
        out_ready = 1'b1;
        exp = ref_vec(v, CONV);
        launch(v, CONV);
        wait_valid(k);
        chk("basic_lat", k, 32'd13);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_q", nmis(q, exp), 32'd0);
        chk("basic_e0", 32'(q[0]), 32'd5);
        chk("basic_e1", 32'(q[1]), 32'd0);
        handshake("basic");
        chk("basic_keep", nmis(q, exp), 32'd0);
        tick();

        launch(v, AFF);
        wait_valid(k);
        chk("aff_lat", k, 32'd13);
        chk("aff_q", nmis(q, v), 32'd0);
        chk("aff_e1", 32'(q[1]), 32'h0000FFFB);
        handshake("aff");
        tick();

        for (int t = 0; t < 6; t++) begin
            logic [3:0] cs;
            v  = rand_vec();
            cs = (t % 3 == 2) ? AFF : CONV;
            if (t == 0) v[0] = 16'h8000;
            if (t == 1) begin
                v[0] = 16'h0200;
                v[1] = 16'h00FF;
                v[2] = 16'h8000;
            end
            exp = ref_vec(v, cs);
            launch(v, cs);
            wait_valid(k);
            chk("rnd_lat", k, 32'd13);
            chk("rnd_q", nmis(q, exp), 32'd0);
            if (t == 0) chk("min_e0", 32'(q[0]), 32'd0);
            if (t == 1) begin
`ifdef RELU_SAT_EN
                chk("sat_e0", 32'(q[0]), 32'h0100);
`else
                chk("sat_e0", 32'(q[0]), 32'h0200);
`endif
                chk("sat_e1", 32'(q[1]), 32'h00FF);
                chk("sat_e2", 32'(q[2]), 32'h0000);
            end
            handshake("rnd");
            tick();
        end

        out_ready = 1'b0;
        v = rand_vec();
        exp = ref_vec(v, CONV);
        in_valid = 1'b1;
        d = v;
        cs_layer = CONV;
        fork
            begin
                repeat (40) @(posedge clk);
                #1 in_valid = 1'b0;
            end
        join_none
        tick();
        wait_valid(k);
        chk("hold_lat", k, 32'd13);
        for (int c = 0; c < 20; c++) begin
            chk("hold_vld", 32'(out_valid), 32'd1);
            chk("hold_q", nmis(q, exp), 32'd0);
            tick();
        end
        handshake("hold");
        repeat (10) tick();
        chk("hold_once_vld", 32'(out_valid), 32'd0);
        chk("hold_once_busy", 32'(busy), 32'd0);
        chk("hold_ovr", 32'(overrun), 32'd0);
        tick();

        out_ready = 1'b1;
        v  = rand_vec();
        v2 = rand_vec();
        exp = ref_vec(v, CONV);
        launch(v, CONV);
        repeat (5) tick();
        launch(v2, AFF);
        wait_valid(k);
        chk("ovr_lat", k + 6, 32'd13);
        chk("ovr_q", nmis(q, exp), 32'd0);
        chk("ovr_flag", 32'(overrun), 32'd1);
        handshake("ovr");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        tick();

        v = rand_vec();
        launch(v, CONV);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_q", nmis(q, '0), 32'd0);
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        repeat (20) tick();
        chk("arst_no_out", 32'(out_valid), 32'd0);
        v = rand_vec();
        exp = ref_vec(v, CONV);
        launch(v, CONV);
        wait_valid(k);
        chk("arst_lat", k, 32'd13);
        chk("arst_new_q", nmis(q, exp), 32'd0);
        handshake("arst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
